imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time writer for the instruction memory: receives a framed byte stream, assembles
//  little-endian 32-bit words and drives the imem write port (data, address, enable).
//  Holds the core in reset (cpu_reset_o) until a complete image is written, then releases it.
//  Sits beside the fetch stage; fetch is the imem reader, this block is the imem writer.
// PARAMETERS
//  BASE_ADDR   32'h0000_0000  byte address of the first word written (word-aligned)
//  MAX_WORDS   256            largest accepted image, in words; the header count is checked against it
// PORTS
//  clk              in   1   clock
//  reset            in   1   asynchronous, active-low reset
//  start_i          in   1   one-cycle pulse: begin a load (honoured in IDLE/DONE/ERR only)
//  byte_valid_i     in   1   byte_data_i valid
//  byte_data_i      in   8   stream byte
//  byte_ready_o     out  1   loader can accept a byte this cycle
//  wr_en_imem_o     out  1   imem write strobe (one cycle per word)
//  wr_addr_imem_o   out  32  imem byte address of the write
//  wr_instr_imem_o  out  32  instruction word to write
//  cpu_reset_o      out  1   active-high core reset request
//  done_o           out  1   image loaded OK (level)
//  err_o            out  1   load aborted (level)
// BEHAVIOUR
//  Frame: 4 header bytes = word count N (LSB first), then N words of 4 bytes each (LSB first).
//  Byte transfer occurs on clk edge when byte_valid_i & byte_ready_o.
//  Reset values: state=IDLE, byte_ready_o=0, wr_en_imem_o=0, wr_addr/wr_instr=0,
//   cpu_reset_o=1, done_o=0, err_o=0. Counters and word buffer cleared.
//  FSM: IDLE -start_i-> HDR; HDR (ready=1) after 4th byte: N==0 -> DONE, N>MAX_WORDS -> ERR,
//   else DATA; DATA (ready=1) after 4th byte -> WRITE; WRITE (ready=0): wr_en_imem_o=1 for
//   exactly one cycle, addr=BASE_ADDR+4*idx, idx++; idx==N -> DONE (or CHK), else DATA.
//  Latency: write strobe is registered, asserted the cycle after the 4th byte of a word is accepted.
//  byte_ready_o=0 in IDLE, WRITE, DONE, ERR. Byte counter is 2 bits and wraps per word.
//  Word index counts 0..N-1 in a 32-bit counter; the address is formed with 32-bit add, wrap ignored.
//  DONE: cpu_reset_o=0, done_o=1. ERR: cpu_reset_o stays 1, err_o=1.
//  start_i in DONE/ERR: -> HDR, cpu_reset_o=1, done_o/err_o cleared same edge. start_i in HDR/DATA/WRITE/CHK is ignored.
//  byte_valid_i low mid-word: hold state and partial word indefinitely (no timeout).
//  Reset mid-load: immediate return to reset values; words already written are not scrubbed.
// CONFIGURATION
//  `LOADER_CHECKSUM_EN defined: after the last WRITE -> CHK; accept 4 more bytes (LSB first) and compare
//   them with the running XOR of all N words. Match -> DONE, mismatch -> ERR. For N==0, HDR -> CHK and
//   the expected value is 0.
//  Not defined: no CHK state; last WRITE -> DONE; trailing bytes are left unconsumed (ready=0).
// STRUCTURE
//  Shared include loader_defs.vh: FSM state encodings (IDLE,HDR,DATA,WRITE,CHK,DONE,ERR),
//   LOADER_HDR_BYTES=4 and LOADER_WORD_BYTES=4.
//  Sub-module byte_assembler: 2-bit byte counter + 32-bit LSB-first shift register; outputs word and
//   word_complete. It is reused for header, payload and checksum.
// TESTING
//  1. Reset low, release, start_i, N=2, words 0x2008_0005, 0x0000_0000 -> writes at 0x0 and 0x4
//     with the exact data; then done_o=1 and cpu_reset_o=0.
//  2. Header N=0 -> DONE with zero writes (checksum build: expects checksum 0x0000_0000).
//  3. Header N=MAX_WORDS+1 -> err_o=1, cpu_reset_o=1, no wr_en_imem_o pulse.
//  4. byte_valid_i toggling every other cycle mid-word -> the same word and address as back-to-back;
//     exactly one strobe per word.
//  5. Reset asserted after 6 payload bytes -> all outputs return to reset values next cycle; a new
//     start_i reloads from BASE_ADDR.
//  6. Checksum build, N=2: correct XOR -> DONE; flipping bit 0 of the checksum -> ERR.
//     Then start_i -> HDR with err_o cleared.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the instruction-memory boot loader:
//   FSM state encoding, frame geometry and the word-address helper.
//   Optional feature macro used by the loader: LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } loader_state_e;

    localparam int LOADER_HDR_BYTES  = 4;
    localparam int LOADER_WORD_BYTES = 4;

    // Byte address of word idx; 32-bit add, wrap-around is intentionally ignored.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] idx);
        return base + {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// -----------------------------------------------------------------------------
// imem_loader_byte_assembler
//   Collects LSB-first bytes into a 32-bit word. Used for the header count,
//   every payload word and (optionally) the trailing checksum.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   clear           synchronous restart of the byte counter and buffer
//   byte_en         a byte is transferred this cycle
//   byte_data       the transferred byte
//   word            assembled word (valid while word_complete is high)
//   word_complete   high in the cycle the last byte of a word is transferred
// -----------------------------------------------------------------------------
module imem_loader_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_complete
);

    localparam logic [1:0] LAST_BYTE = 2'(LOADER_WORD_BYTES - 1);

    logic [1:0]  cnt_q;
    // Only the first three bytes need storing; the fourth is taken live from
    // byte_data so the complete word is available in its transfer cycle.
    logic [23:0] shift_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (clear) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (byte_en) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {byte_data, shift_q[23:8]};
        end
    end

    assign word          = {byte_data, shift_q};
    assign word_complete = byte_en && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time instruction-memory writer. Receives a framed byte stream
//   (4-byte LSB-first word count N, then N LSB-first words), writes each word
//   to imem and holds the core in reset until the image is complete.
//   Optional macro LOADER_CHECKSUM_EN: a 4-byte XOR checksum of all words
//   follows the payload; mismatch aborts the load.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   start_i             begin a load (honoured in IDLE/DONE/ERR only)
//   byte_valid_i/_data_i  incoming stream byte
//   byte_ready_o        loader accepts a byte this cycle
//   wr_en_imem_o        one-cycle imem write strobe per word
//   wr_addr_imem_o      imem byte address of the write
//   wr_instr_imem_o     instruction word written
//   cpu_reset_o         core reset request (high until a good image is loaded)
//   done_o / err_o      load finished OK / load aborted
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        wr_en_imem_o,
    output logic [31:0] wr_addr_imem_o,
    output logic [31:0] wr_instr_imem_o,
    output logic        cpu_reset_o,
    output logic        done_o,
    output logic        err_o
);

    loader_state_e state_q, state_d;

    logic        start_load;
    logic        byte_xfer;
    logic [31:0] word;
    logic        word_complete;

    logic [31:0] count_q;
    logic [31:0] idx_q;
    logic        wr_en_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_instr_q;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] csum_q;
`endif

    assign byte_ready_o = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CHK);
    assign byte_xfer    = byte_valid_i && byte_ready_o;

    imem_loader_byte_assembler u_asm (
        .clk           (clk),
        .reset         (reset),
        .clear         (start_load),
        .byte_en       (byte_xfer),
        .byte_data     (byte_data_i),
        .word          (word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        start_load = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d    = ST_HDR;
                    start_load = 1'b1;
                end
            end
            ST_HDR: begin
                if (word_complete) begin
                    if (word == 32'd0)
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
`endif
                    else if (word > 32'(MAX_WORDS))
                        state_d = ST_ERR;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_complete) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (idx_q + 32'd1 == count_q)
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_DONE;
`endif
                else
                    state_d = ST_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (word_complete) state_d = (word == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Write port is registered: the strobe appears the cycle after the last
    // byte of a word is accepted, which is exactly the WRITE state cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            idx_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_instr_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            if (start_load) begin
                count_q <= '0;
                idx_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum_q  <= '0;
`endif
            end
            if (state_q == ST_HDR && word_complete)
                count_q <= word;
            if (state_q == ST_DATA && word_complete) begin
                wr_en_q    <= 1'b1;
                wr_addr_q  <= word_addr(BASE_ADDR, idx_q);
                wr_instr_q <= word;
`ifdef LOADER_CHECKSUM_EN
                csum_q     <= csum_q ^ word;
`endif
            end
            if (state_q == ST_WRITE)
                idx_q <= idx_q + 32'd1;
        end
    end

    assign wr_en_imem_o    = wr_en_q;
    assign wr_addr_imem_o  = wr_addr_q;
    assign wr_instr_imem_o = wr_instr_q;
    assign cpu_reset_o     = (state_q != ST_DONE);
    assign done_o          = (state_q == ST_DONE);
    assign err_o           = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader (default BASE_ADDR/MAX_WORDS). Steps that
//   depend on the checksum frame follow the LOADER_CHECKSUM_EN macro.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'h00;
    logic        byte_ready_o;
    logic        wr_en_imem_o;
    logic [31:0] wr_addr_imem_o;
    logic [31:0] wr_instr_imem_o;
    logic        cpu_reset_o;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;

    // Write log captured away from the active edge.
    int          wr_cnt = 0;
    logic [31:0] log_addr [0:63];
    logic [31:0] log_data [0:63];

    imem_loader dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .byte_valid_i    (byte_valid_i),
        .byte_data_i     (byte_data_i),
        .byte_ready_o    (byte_ready_o),
        .wr_en_imem_o    (wr_en_imem_o),
        .wr_addr_imem_o  (wr_addr_imem_o),
        .wr_instr_imem_o (wr_instr_imem_o),
        .cpu_reset_o     (cpu_reset_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en_imem_o && wr_cnt < 64) begin
            log_addr[wr_cnt] = wr_addr_imem_o;
            log_data[wr_cnt] = wr_instr_imem_o;
        end
        if (wr_en_imem_o) wr_cnt = wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one byte; optional idle cycle first to create gaps in the stream.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        if (gap) begin
            @(negedge clk);
            byte_valid_i = 1'b0;
        end
        @(negedge clk);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        while (!byte_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(byte_ready_o), 32'd1);
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send_byte(w[7:0],   gap);
        send_byte(w[15:8],  gap);
        send_byte(w[23:16], gap);
        send_byte(w[31:24], gap);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},  32'(byte_ready_o), 32'd0);
        check({tag, "_wr_en"},  32'(wr_en_imem_o), 32'd0);
        check({tag, "_addr"},   wr_addr_imem_o,    32'd0);
        check({tag, "_instr"},  wr_instr_imem_o,   32'd0);
        check({tag, "_cpurst"}, 32'(cpu_reset_o),  32'd1);
        check({tag, "_done"},   32'(done_o),       32'd0);
        check({tag, "_err"},    32'(err_o),        32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Reset state
        idle(3);
        check_reset_values("rst");
        reset = 1'b1;
        idle(2);
        check("idle_ready", 32'(byte_ready_o), 32'd0);

        // Test 1: N=2, words 0x20080005 and 0x00000000
        base = wr_cnt;
        pulse_start();
        check("t1_hdr_ready", 32'(byte_ready_o), 32'd1);
        check("t1_hdr_cpurst", 32'(cpu_reset_o), 32'd1);
        send_word(32'd2, 1'b0);
        send_word(32'h2008_0005, 1'b0);
        check("t1_strobe_lat", 32'(wr_en_imem_o), 32'd1);
        check("t1_strobe_addr", wr_addr_imem_o, 32'h0);
        send_word(32'h0000_0000, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h2008_0005, 1'b0);
`endif
        idle(3);
        check("t1_nwr", 32'(wr_cnt - base), 32'd2);
        check("t1_addr0", log_addr[base],     32'h0);
        check("t1_data0", log_data[base],     32'h2008_0005);
        check("t1_addr1", log_addr[base + 1], 32'h4);
        check("t1_data1", log_data[base + 1], 32'h0);
        check("t1_done", 32'(done_o), 32'd1);
        check("t1_cpurst", 32'(cpu_reset_o), 32'd0);
        check("t1_err", 32'(err_o), 32'd0);
        check("t1_done_ready", 32'(byte_ready_o), 32'd0);

        // Test 2: N=0 goes straight to DONE with no writes
        base = wr_cnt;
        pulse_start();
        check("t2_done_clr", 32'(done_o), 32'd0);
        check("t2_cpurst_set", 32'(cpu_reset_o), 32'd1);
        send_word(32'd0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'd0, 1'b0);
`endif
        idle(2);
        check("t2_done", 32'(done_o), 32'd1);
        check("t2_nwr", 32'(wr_cnt - base), 32'd0);

        // Test 3: N=257 exceeds MAX_WORDS
        base = wr_cnt;
        pulse_start();
        send_word(32'd257, 1'b0);
        idle(3);
        check("t3_err", 32'(err_o), 32'd1);
        check("t3_cpurst", 32'(cpu_reset_o), 32'd1);
        check("t3_done", 32'(done_o), 32'd0);
        check("t3_nwr", 32'(wr_cnt - base), 32'd0);
        check("t3_ready", 32'(byte_ready_o), 32'd0);

        // Test 4: gapped stream, N=1 word 0xA1B2C3D4
        base = wr_cnt;
        pulse_start();
        check("t4_err_clr", 32'(err_o), 32'd0);
        send_word(32'd1, 1'b1);
        send_word(32'hA1B2_C3D4, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'hA1B2_C3D4, 1'b1);
`endif
        idle(3);
        check("t4_nwr", 32'(wr_cnt - base), 32'd1);
        check("t4_addr", log_addr[base], 32'h0);
        check("t4_data", log_data[base], 32'hA1B2_C3D4);
        check("t4_done", 32'(done_o), 32'd1);

        // Test 5: reset after 6 payload bytes, then reload
        base = wr_cnt;
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'h4433_2211, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        check("t5_partial_nwr", 32'(wr_cnt - base), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("t5_rst");
        reset = 1'b1;
        base = wr_cnt;
        pulse_start();
        send_word(32'd1, 1'b0);
        send_word(32'hCAFE_F00D, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'hCAFE_F00D, 1'b0);
`endif
        idle(3);
        check("t5_nwr", 32'(wr_cnt - base), 32'd1);
        check("t5_addr", log_addr[base], 32'h0);
        check("t5_data", log_data[base], 32'hCAFE_F00D);
        check("t5_done", 32'(done_o), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Test 6: checksum 1^2=3 accepted, 2 (bit 0 flipped) rejected
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd3, 1'b0);
        idle(2);
        check("t6_good_done", 32'(done_o), 32'd1);
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd2, 1'b0);
        idle(2);
        check("t6_bad_err", 32'(err_o), 32'd1);
        check("t6_bad_cpurst", 32'(cpu_reset_o), 32'd1);
        pulse_start();
        check("t6_err_clr", 32'(err_o), 32'd0);
        check("t6_hdr_ready", 32'(byte_ready_o), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
